// File: rtl/rv32i_mc_control.sv
// Multi-cycle RV32I control FSM: fetch, decode, execute, memory, mul/div wait, writeback, trap.
// Outputs are Mealy decodes of the current state, opcode and handshake inputs.
module rv32i_mc_control #(
   parameter bit ENABLE_M        = 1'b0,
   parameter bit HALT_ON_ILLEGAL = 1'b1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [6:0] i_opcode,
   input  logic [6:0] i_funct7,
   input  logic       i_imem_ack,
   input  logic       i_dmem_ack,
   input  logic       i_muldiv_done,
   input  logic       i_branch_taken,
   output logic       o_imem_req,
   output logic       o_ir_write,
   output logic       o_dmem_req,
   output logic       o_dmem_we,
   output logic       o_muldiv_start,
   output logic       o_pc_write,
   output logic [1:0] o_pc_sel,
   output logic       o_alu_src,
   output logic [1:0] o_alu_op_main,
   output logic [2:0] o_imm_type,
   output logic       o_reg_write,
   output logic [1:0] o_wb_sel,
   output logic       o_illegal_instr,
   output logic       o_retire,
   output logic [2:0] o_state
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_MULDIV = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_TRAP   = 3'd7;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;

   logic [2:0] r_state;
   logic       r_rst;
   logic [2:0] w_state_d;
   logic       w_known;
   logic       w_is_m;
   logic       w_legal;
   logic       w_alu_src;
   logic [1:0] w_alu_op;
   logic [2:0] w_imm;
   logic [1:0] w_wb;
   logic       w_in_instr;

   assign w_is_m     = (i_opcode == OPC_OP) && (i_funct7 == 7'b0000001);
   assign w_legal    = w_known && !(w_is_m && !ENABLE_M);
   assign w_in_instr = (r_state == S_DECODE) || (r_state == S_EXEC) || (r_state == S_MEM) ||
                       (r_state == S_MULDIV) || (r_state == S_WB);

   always_comb begin
      w_known   = 1'b1;
      w_alu_src = 1'b0;
      w_alu_op  = 2'b00;
      w_imm     = 3'd0;
      w_wb      = 2'b00;
      case (i_opcode)
         OPC_LUI, OPC_AUIPC: begin w_alu_src = 1'b1; w_imm = 3'd3; end
         OPC_JAL:    begin w_alu_src = 1'b1; w_imm = 3'd4; w_wb = 2'b10; end
         OPC_JALR:   begin w_alu_src = 1'b1; w_wb = 2'b10; end
         OPC_BRANCH: begin w_alu_op = 2'b01; w_imm = 3'd2; end
         OPC_LOAD:   begin w_alu_src = 1'b1; w_wb = 2'b01; end
         OPC_STORE:  begin w_alu_src = 1'b1; w_imm = 3'd1; end
         OPC_OPIMM:  begin w_alu_src = 1'b1; w_alu_op = 2'b11; end
         OPC_OP:     begin w_alu_op = 2'b10; if (w_is_m) w_wb = 2'b11; end
         OPC_FENCE:  ;
         default:    w_known = 1'b0;
      endcase
   end

   always_comb begin
      w_state_d       = r_state;
      o_imem_req      = 1'b0;
      o_ir_write      = 1'b0;
      o_dmem_req      = 1'b0;
      o_dmem_we       = 1'b0;
      o_muldiv_start  = 1'b0;
      o_pc_write      = 1'b0;
      o_pc_sel        = 2'b00;
      o_alu_src       = 1'b0;
      o_alu_op_main   = 2'b00;
      o_imm_type      = 3'd0;
      o_reg_write     = 1'b0;
      o_wb_sel        = 2'b00;
      o_illegal_instr = 1'b0;
      o_retire        = 1'b0;
      o_state         = r_state;
      // The cycle after a reset edge is kept silent so late acks cannot advance the FSM.
      if (r_rst) begin
         w_state_d = S_FETCH;
      end else begin
         if (w_in_instr && w_legal) begin
            o_alu_src     = w_alu_src;
            o_alu_op_main = w_alu_op;
            o_imm_type    = w_imm;
            o_wb_sel      = w_wb;
         end
         case (r_state)
            S_FETCH: begin
               o_imem_req = 1'b1;
               if (i_imem_ack) begin
                  o_ir_write = 1'b1;
                  w_state_d  = S_DECODE;
               end
            end
            S_DECODE: w_state_d = w_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
               if (i_opcode == OPC_BRANCH) begin
                  o_pc_write = 1'b1;
                  o_pc_sel   = i_branch_taken ? 2'b01 : 2'b00;
                  o_retire   = 1'b1;
                  w_state_d  = S_FETCH;
               end else if ((i_opcode == OPC_LOAD) || (i_opcode == OPC_STORE)) begin
                  w_state_d = S_MEM;
               end else if (w_is_m) begin
                  o_muldiv_start = 1'b1;
                  w_state_d      = S_MULDIV;
               end else if (i_opcode == OPC_FENCE) begin
                  o_pc_write = 1'b1;
                  o_retire   = 1'b1;
                  w_state_d  = S_FETCH;
               end else begin
                  w_state_d = S_WB;
               end
            end
            S_MEM: begin
               o_dmem_req = 1'b1;
               o_dmem_we  = (i_opcode == OPC_STORE);
               if (i_dmem_ack) begin
                  if (i_opcode == OPC_STORE) begin
                     o_pc_write = 1'b1;
                     o_retire   = 1'b1;
                     w_state_d  = S_FETCH;
                  end else begin
                     w_state_d = S_WB;
                  end
               end
            end
            S_MULDIV: if (i_muldiv_done) w_state_d = S_WB;
            S_WB: begin
               o_reg_write = 1'b1;
               o_pc_write  = 1'b1;
               o_retire    = 1'b1;
               if (i_opcode == OPC_JAL)       o_pc_sel = 2'b01;
               else if (i_opcode == OPC_JALR) o_pc_sel = 2'b10;
               w_state_d = S_FETCH;
            end
            S_TRAP: begin
               o_illegal_instr = 1'b1;
               if (!HALT_ON_ILLEGAL) begin
                  o_pc_write = 1'b1;
                  w_state_d  = S_FETCH;
               end
            end
            default: w_state_d = S_FETCH;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_FETCH;
         r_rst   <= 1'b1;
      end else begin
         r_state <= w_state_d;
         r_rst   <= 1'b0;
      end
   end

endmodule
